// File: rtl/pwm_ramp_controller.sv
// Ramps a PWM duty toward a commanded target, one step every STEP_DIV PWM periods; cmd_ready gates new commands.
// Latency: outputs registered, one cycle after accept / period_end. Optional soft stop under macro PWM_RAMP_SOFTSTOP_EN.
module pwm_ramp_controller #(
    parameter int WIDTH    = 8,
    parameter int STEP_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_duty,
    input  logic [WIDTH-1:0] cmd_period,
    input  logic [WIDTH-1:0] cmd_step,
    input  logic             period_end,
    output logic [WIDTH-1:0] duty,
    output logic [WIDTH-1:0] period,
    output logic             pwm_enable,
    output logic             busy,
    output logic             done
);

`ifdef PWM_RAMP_SOFTSTOP_EN
    typedef enum logic [1:0] {IDLE, RAMP, HOLD, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, RAMP, HOLD} state_t;
`endif

    localparam logic [7:0] DIV_LAST = 8'(STEP_DIV - 1);

    state_t           state;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] step_size;
    logic [WIDTH-1:0] shadow;
    logic             pend;
    logic [7:0]       div;
    logic             accept;
    logic [WIDTH:0]   up_sum;
    logic [WIDTH-1:0] step_nxt;

    // Ready is a decode of the registered state, qualified by enable and forced low in reset.
    assign cmd_ready = enable && !rst && (state == IDLE || state == HOLD);
    assign accept    = cmd_valid && cmd_ready;

    // Saturating step toward the target; the upward sum is one bit wider so it cannot wrap.
    always_comb begin
        up_sum   = {1'b0, duty} + {1'b0, step_size};
        step_nxt = target;
        if (duty < target) begin
            step_nxt = (up_sum > {1'b0, target}) ? target : up_sum[WIDTH-1:0];
        end else if ((duty - target) > step_size) begin
            step_nxt = duty - step_size;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            duty       <= '0;
            period     <= '0;
            pwm_enable <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            target     <= '0;
            step_size  <= '0;
            shadow     <= '0;
            pend       <= 1'b0;
            div        <= '0;
        end else begin
            done <= 1'b0;
            if (state != IDLE && period_end && pend && !accept) begin
                period <= shadow;
                pend   <= 1'b0;
            end
            if ((state == RAMP || state == HOLD) && !enable) begin
`ifdef PWM_RAMP_SOFTSTOP_EN
                if (duty == '0) begin
                    state      <= IDLE;
                    pwm_enable <= 1'b0;
                    busy       <= 1'b0;
                    div        <= '0;
                    pend       <= 1'b0;
                end else begin
                    state  <= STOP;
                    target <= '0;
                    busy   <= 1'b1;
                    div    <= '0;
                end
`else
                state      <= IDLE;
                pwm_enable <= 1'b0;
                duty       <= '0;
                busy       <= 1'b0;
                div        <= '0;
                pend       <= 1'b0;
`endif
            end else begin
                case (state)
                    IDLE, HOLD: begin
                        if (accept) begin
                            target    <= cmd_duty;
                            step_size <= (cmd_step == '0) ? WIDTH'(1) : cmd_step;
                            div       <= '0;
                            if (state == IDLE) begin
                                period     <= cmd_period;
                                pwm_enable <= 1'b1;
                                duty       <= '0;
                            end else begin
                                shadow <= cmd_period;
                                pend   <= 1'b1;
                            end
                            if (cmd_duty == ((state == IDLE) ? '0 : duty)) begin
                                state <= HOLD;
                                done  <= 1'b1;
                            end else begin
                                state <= RAMP;
                                busy  <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        if (period_end) begin
                            if (div == DIV_LAST) begin
                                div  <= '0;
                                duty <= step_nxt;
                                if (step_nxt == target) begin
                                    busy <= 1'b0;
`ifdef PWM_RAMP_SOFTSTOP_EN
                                    if (state == STOP) begin
                                        state      <= IDLE;
                                        pwm_enable <= 1'b0;
                                        pend       <= 1'b0;
                                    end else
`endif
                                    begin
                                        state <= HOLD;
                                        done  <= 1'b1;
                                    end
                                end
                            end else begin
                                div <= div + 8'd1;
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/pwm_ramp_controller.md
PWM_RAMP_CONTROLLER -- requirements
Module: pwm_ramp_controller

Interface
REQ-001 SHALL have parameter WIDTH, default 8, which sets the duty, period and step width in bits.
REQ-002 SHALL have parameter STEP_DIV, default 4, which sets the number of PWM periods between duty steps (legal range 1..255).
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port enable, input, 1 bit: run request; low requests stop.
REQ-006 SHALL have port cmd_valid, input, 1 bit: command valid.
REQ-007 SHALL have port cmd_ready, output, 1 bit: command can be accepted.
REQ-008 SHALL have port cmd_duty, input, WIDTH bits: target duty.
REQ-009 SHALL have port cmd_period, input, WIDTH bits: new PWM period.
REQ-010 SHALL have port cmd_step, input, WIDTH bits: duty increment per step.
REQ-011 SHALL have port period_end, input, 1 bit: one-cycle pulse from the PWM generator at each counter wrap.
REQ-012 SHALL have port duty, output, WIDTH bits: duty value driven to the PWM generator.
REQ-013 SHALL have port period, output, WIDTH bits: period value driven to the PWM generator.
REQ-014 SHALL have port pwm_enable, output, 1 bit: enable driven to the PWM generator.
REQ-015 SHALL have port busy, output, 1 bit: high in RAMP or STOP.
REQ-016 SHALL have port done, output, 1 bit: one-cycle pulse when the target duty is reached.

Function
REQ-017 SHALL implement the states IDLE, RAMP, HOLD and STOP; all outputs SHALL be registered.
REQ-018 cmd_ready SHALL equal enable AND (state is IDLE or HOLD); a command is accepted on the cycle where cmd_valid and cmd_ready are both high.
REQ-019 On acceptance the block SHALL latch target=cmd_duty and step=max(cmd_step,1); a cmd_step of 0 SHALL be treated as 1.
REQ-020 On acceptance in IDLE: period SHALL load cmd_period on the next cycle, pwm_enable SHALL go to 1, duty SHALL start at 0, and the state SHALL go to RAMP.
REQ-021 On acceptance in HOLD: cmd_period SHALL be held in a shadow register, and period SHALL load it at the first period_end strictly after the accept cycle; the state SHALL go to RAMP.
REQ-022 If the target equals the current duty at acceptance, the state SHALL go directly to HOLD, and done SHALL pulse on the next cycle.
REQ-023 In RAMP, each period_end SHALL advance a divider; on every STEP_DIV-th period_end the divider SHALL clear and duty SHALL step toward the target.
REQ-024 Upward steps SHALL compute min(duty+step, target) in WIDTH+1 bits, with no wrap-around.
REQ-025 Downward steps SHALL compute max(duty-step, target), saturating at the target.
REQ-026 When duty equals the target after a step, the state SHALL go to HOLD and done SHALL pulse for one cycle.
REQ-027 A period_end coincident with an acceptance SHALL NOT count toward the divider or load the period.
REQ-028 The divider SHALL clear on every acceptance.
REQ-029 duty SHALL change only on a step event, on IDLE entry, or on reset.
REQ-030 Stop behaviour when enable goes low in RAMP or HOLD SHALL be as given in REQ-035/REQ-036; in IDLE, enable low SHALL have no effect.

Reset
REQ-031 rst high SHALL immediately (asynchronously) force state=IDLE.
REQ-032 rst high SHALL immediately force duty=0, period=0, pwm_enable=0, busy=0, done=0, cmd_ready=0, the divider to 0 and the shadow register to 0.
REQ-033 A reset asserted mid-ramp or mid-stop SHALL abandon the operation with no done pulse.
REQ-034 After rst deasserts, the block SHALL accept a command on the first cycle with enable=1 and cmd_valid=1.

Configuration
REQ-035 With macro PWM_RAMP_SOFTSTOP_EN defined, enable low in RAMP or HOLD SHALL enter STOP with target=0, stepping down at the same rate with the last step; at duty=0 the state SHALL go to IDLE and pwm_enable SHALL go to 0. Enable reasserting during STOP SHALL NOT abort it, and cmd_ready SHALL be 0 in STOP.
REQ-036 Without PWM_RAMP_SOFTSTOP_EN, enable low in RAMP or HOLD SHALL go to IDLE on the next cycle with pwm_enable=0 and duty=0; period SHALL hold its value. The STOP state SHALL NOT be present.

Verification (WIDTH=8, STEP_DIV=2)
REQ-037 Ramp up: from IDLE, accept duty=40, step=10, period=99 -> period=99 and pwm_enable=1 next cycle; duty takes 10/20/30/40 at period_end #2/#4/#6/#8; done pulses once; state is HOLD.
REQ-038 Clamp: from HOLD at 40, accept duty=5, step=16 -> duty takes 24, 8, 5; done pulses; no underflow.
REQ-039 Zero step and no-op: accept step=0, duty=43 from 40 -> 41, 42, 43. Then accept duty=43 -> HOLD with done pulsing next cycle and no duty change.
REQ-040 Period sync: in HOLD, accept period=49 on the same cycle as a period_end -> period stays 99 until the next period_end, then becomes 49; the coincident pulse does not count toward the divider.
REQ-041 Stop: at duty=40 with step=10, drop enable -> with the macro, duty takes 30/20/10/0 every 2 period_ends, then pwm_enable=0; without the macro, pwm_enable=0 and duty=0 on the next cycle.
REQ-042 Reset mid-ramp: assert rst between clock edges -> all outputs reach their reset values before the next edge, with no done pulse.
